wb_coherency_ctrl: RTL and testbench

WB_COHERENCY_CTRL -- requirements
Module: wb_coherency_ctrl

---
 rtl/cache_pkg.sv | 26 ++
 rtl/wb_ack_timer.sv | 49 ++++
 rtl/wb_coherency_ctrl.sv | 133 +++++++++++++
 tb/tb_wb_coherency_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types and constants for the write-back coherency controller.
package cache_pkg;

  localparam int DEF_ADDR_W    = 10;
  localparam int DEF_DATA_W    = 16;
  localparam int DEF_MAX_RETRY = 3;

  // Cycles the controller waits for a tag hit after accepting a write.
  localparam int LOOKUP_WINDOW = 2;
  // Cycles bus_req is held per invalidate attempt before backing off.
  localparam int ACK_WINDOW    = 2;

  typedef logic [DEF_ADDR_W-1:0] addr_t;
  typedef logic [DEF_DATA_W-1:0] data_t;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    MARK,
    INV,
    INV_BACKOFF,
    WB,
    DONE
  } state_t;

endpackage

// File: rtl/wb_ack_timer.sv
// Invalidate acknowledge window and retry bookkeeping.
// timeout fires on the last window cycle without an ack (ack wins a tie);
// exhausted reports that the allowed number of retries has been used.
module wb_ack_timer
  import cache_pkg::*;
#(
  parameter int MAX_RETRY = DEF_MAX_RETRY
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  input  logic ack,
  output logic timeout,
  output logic exhausted
);

  localparam int WIN_W = $clog2(ACK_WINDOW);
  localparam int CNT_W = $clog2(MAX_RETRY + 1);

  logic [WIN_W-1:0] win_cnt;
  logic [CNT_W-1:0] retry_cnt;

  assign timeout   = run && !ack && (win_cnt == WIN_W'(ACK_WINDOW - 1));
  assign exhausted = (retry_cnt == CNT_W'(MAX_RETRY));

  // Count cycles spent waiting inside one invalidate attempt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_cnt <= '0;
    end else if (run && !ack && !timeout) begin
      win_cnt <= win_cnt + WIN_W'(1);
    end else begin
      win_cnt <= '0;
    end
  end

  // Count failed attempts; restarted for every newly accepted write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retry_cnt <= '0;
    end else if (clear) begin
      retry_cnt <= '0;
    end else if (timeout && !exhausted) begin
      retry_cnt <= retry_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/wb_coherency_ctrl.sv
// Write-hit coherency controller: lookup, mark dirty, broadcast invalidate
// with bounded retries, then write the captured data back to memory.
module wb_coherency_ctrl
  import cache_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_RETRY = DEF_MAX_RETRY
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr_write,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              cache_hit,
  output logic              busy,
  output logic              dirty_set,
  output logic [ADDR_W-1:0] line_addr,
  output logic              bus_req,
  input  logic              ack,
  output logic              mem_wr_req,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic              mem_wr_ack,
  output logic              done,
  output logic              err
);

  localparam int LK_W = $clog2(LOOKUP_WINDOW);

  state_t          state;
  state_t          state_nxt;
  logic [LK_W-1:0] lk_cnt;
  logic            lk_last;
  logic            accept;
  logic            in_inv;
  logic            inv_timeout;
  logic            retry_exhausted;

  assign accept  = (state == IDLE) && wr;
  assign in_inv  = (state == INV);
  assign lk_last = (lk_cnt == LK_W'(LOOKUP_WINDOW - 1));

  wb_ack_timer #(
    .MAX_RETRY (MAX_RETRY)
  ) u_ack_timer (
    .clk       (clk),
    .rst       (rst),
    .clear     (accept),
    .run       (in_inv),
    .ack       (ack),
    .timeout   (inv_timeout),
    .exhausted (retry_exhausted)
  );

  // State register; reset aborts any transaction without done/err.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Count lookup cycles so a missing hit gives up after the window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lk_cnt <= '0;
    end else if (state == LOOKUP) begin
      lk_cnt <= lk_cnt + LK_W'(1);
    end else begin
      lk_cnt <= '0;
    end
  end

  // Capture address and data only when a write is accepted from IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_addr   <= '0;
      mem_wr_data <= '0;
    end else if (accept) begin
      line_addr   <= addr_write;
      mem_wr_data <= wr_data;
    end
  end

  // Next-state and Moore outputs.
  always_comb begin
    state_nxt  = state;
    busy       = 1'b1;
    dirty_set  = 1'b0;
    bus_req    = 1'b0;
    mem_wr_req = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (wr) state_nxt = LOOKUP;
      end
      LOOKUP: begin
        if (cache_hit)    state_nxt = MARK;
        else if (lk_last) state_nxt = IDLE;
      end
      MARK: begin
        dirty_set = 1'b1;
        state_nxt = INV;
      end
      INV: begin
        bus_req = 1'b1;
        if (ack)              state_nxt = WB;
        else if (inv_timeout) state_nxt = INV_BACKOFF;
      end
      INV_BACKOFF: begin
        // The low cycle after the final failed attempt carries the error.
        err       = retry_exhausted;
        state_nxt = retry_exhausted ? IDLE : INV;
      end
      WB: begin
        mem_wr_req = 1'b1;
        if (mem_wr_ack) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_wb_coherency_ctrl.sv
// Directed bench for wb_coherency_ctrl. Stimulus is a per-cycle table; a
// timeline model derives the expected outputs of every cycle from it.
module tb_wb_coherency_ctrl;
  import cache_pkg::*;

  localparam int N    = 120;
  localparam int MAXR = DEF_MAX_RETRY;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  logic  wr = 1'b0, cache_hit = 1'b0, ack = 1'b0, mem_wr_ack = 1'b0;
  addr_t addr_write = '0;
  data_t wr_data = '0;
  logic  busy, dirty_set, bus_req, mem_wr_req, done, err;
  addr_t line_addr;
  data_t mem_wr_data;

  int checks = 0;
  int errors = 0;

  // stimulus table (inputs held during cycle c)
  logic  s_wr[N], s_hit[N], s_ack[N], s_mack[N], s_rst[N];
  addr_t s_addr[N];
  data_t s_data[N];
  // expected and observed outputs per cycle
  logic  e_busy[N], e_dirty[N], e_bus[N], e_mreq[N], e_done[N], e_err[N];
  addr_t e_addr[N];
  data_t e_data[N];
  logic  o_busy[N], o_dirty[N], o_bus[N], o_mreq[N], o_done[N], o_err[N];
  addr_t o_addr[N];
  data_t o_data[N];

  addr_t m_addr;
  data_t m_data;

  always #5 clk = ~clk;

  wb_coherency_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .wr          (wr),
    .addr_write  (addr_write),
    .wr_data     (wr_data),
    .cache_hit   (cache_hit),
    .busy        (busy),
    .dirty_set   (dirty_set),
    .line_addr   (line_addr),
    .bus_req     (bus_req),
    .ack         (ack),
    .mem_wr_req  (mem_wr_req),
    .mem_wr_data (mem_wr_data),
    .mem_wr_ack  (mem_wr_ack),
    .done        (done),
    .err         (err)
  );

  task automatic chk(input string name, input int cyc, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, got, exp);
    end
  endtask

  // Record expected outputs for one busy cycle; 1 means the transaction is cut off.
  function automatic bit put(int cc, logic b, logic d, logic q, logic m, logic dn, logic er);
    if (cc >= N || s_rst[cc]) return 1'b1;
    e_busy[cc] = b;  e_dirty[cc] = d; e_bus[cc] = q;
    e_mreq[cc] = m;  e_done[cc] = dn; e_err[cc] = er;
    e_addr[cc] = m_addr; e_data[cc] = m_data;
    return 1'b0;
  endfunction

  // Walk one accepted write starting at its first busy cycle; returns the next idle cycle.
  function automatic int txn(int k);
    int c = k;
    int retries = 0;
    bit got = 1'b0;
    for (int i = 0; i < 2 && !got; i++) begin
      if (put(c, 1, 0, 0, 0, 0, 0)) return c;
      got = s_hit[c]; c++;
    end
    if (!got) return c;
    if (put(c, 1, 1, 0, 0, 0, 0)) return c;
    c++;
    got = 1'b0;
    while (!got) begin
      for (int i = 0; i < 2 && !got; i++) begin
        if (put(c, 1, 0, 1, 0, 0, 0)) return c;
        got = s_ack[c]; c++;
      end
      if (!got) begin
        retries++;
        if (put(c, 1, 0, 0, 0, 0, retries == MAXR)) return c;
        c++;
        if (retries == MAXR) return c;
      end
    end
    got = 1'b0;
    while (!got) begin
      if (put(c, 1, 0, 0, 1, 0, 0)) return c;
      got = s_mack[c]; c++;
    end
    if (put(c, 1, 0, 0, 0, 1, 0)) return c;
    return c + 1;
  endfunction

  task automatic idle_cycle(input int c);
    e_busy[c] = 0; e_dirty[c] = 0; e_bus[c] = 0;
    e_mreq[c] = 0; e_done[c] = 0; e_err[c] = 0;
    e_addr[c] = m_addr; e_data[c] = m_data;
  endtask

  task automatic build_model();
    int c = 0;
    m_addr = '0; m_data = '0;
    while (c < N) begin
      if (s_rst[c]) begin
        m_addr = '0; m_data = '0;
        idle_cycle(c); c++;
      end else begin
        idle_cycle(c);
        if (s_wr[c]) begin
          m_addr = s_addr[c]; m_data = s_data[c];
          c = txn(c + 1);
        end else begin
          c++;
        end
      end
    end
  endtask

  task automatic set_wr(input int c, input addr_t a, input data_t d);
    s_wr[c] = 1'b1; s_addr[c] = a; s_data[c] = d;
  endtask

  function automatic int count(input int which, input int lo, input int hi);
    int n = 0;
    for (int i = lo; i <= hi; i++) begin
      case (which)
        0: n += int'(o_dirty[i]);
        1: n += int'(o_bus[i]);
        2: n += int'(o_mreq[i]);
        3: n += int'(o_done[i]);
        4: n += int'(o_err[i]);
        default: n += int'(o_bus[i] && !o_bus[i-1]);
      endcase
    end
    return n;
  endfunction

  initial begin
    for (int i = 0; i < N; i++) begin
      s_wr[i] = 0; s_hit[i] = 0; s_ack[i] = 0; s_mack[i] = 0; s_rst[i] = 0;
      s_addr[i] = '0; s_data[i] = '0;
    end
    s_rst[0] = 1; s_rst[1] = 1;
    // A: fastest path, stray ack during lookup ignored
    set_wr(3, 10'h05A, 16'hBEEF); s_hit[4] = 1; s_ack[4] = 1; s_ack[6] = 1; s_mack[7] = 1;
    // B: no hit at all
    set_wr(12, 10'h100, 16'h0F0F);
    // C: hit in second lookup cycle, ack withheld until retries run out
    set_wr(20, 10'h111, 16'h1234); s_hit[22] = 1;
    // D: ack on last cycle of final attempt, slow write-back, write dropped mid-WB
    set_wr(40, 10'h05A, 16'hCAFE); s_hit[41] = 1; s_ack[50] = 1; s_mack[60] = 1;
    set_wr(55, 10'h3FF, 16'h0000);
    // E: reset during invalidate, then a normal transaction
    set_wr(70, 10'h2AA, 16'h5555); s_hit[71] = 1; s_rst[74] = 1;
    set_wr(76, 10'h0F0, 16'hA5A5); s_hit[78] = 1; s_ack[81] = 1; s_mack[84] = 1;
    // stray handshakes while idle
    s_ack[90] = 1; s_mack[91] = 1; s_hit[92] = 1;

    build_model();

    fork
      begin
        for (int c = 0; c < N; c++) begin
          @(posedge clk); #1;
          rst = s_rst[c]; wr = s_wr[c]; addr_write = s_addr[c]; wr_data = s_data[c];
          cache_hit = s_hit[c]; ack = s_ack[c]; mem_wr_ack = s_mack[c];
        end
      end
      begin
        for (int c = 0; c < N; c++) begin
          @(posedge clk); @(negedge clk);
          o_busy[c] = busy; o_dirty[c] = dirty_set; o_bus[c] = bus_req;
          o_mreq[c] = mem_wr_req; o_done[c] = done; o_err[c] = err;
          o_addr[c] = line_addr; o_data[c] = mem_wr_data;
          chk("busy", c, 32'(busy), 32'(e_busy[c]));
          chk("dirty_set", c, 32'(dirty_set), 32'(e_dirty[c]));
          chk("bus_req", c, 32'(bus_req), 32'(e_bus[c]));
          chk("mem_wr_req", c, 32'(mem_wr_req), 32'(e_mreq[c]));
          chk("done", c, 32'(done), 32'(e_done[c]));
          chk("err", c, 32'(err), 32'(e_err[c]));
          chk("line_addr", c, 32'(line_addr), 32'(e_addr[c]));
          chk("mem_wr_data", c, 32'(mem_wr_data), 32'(e_data[c]));
        end
      end
    join

    // hand-computed pins on the model
    chk("model_done_A", 8, 32'(e_done[8]), 32'd1);
    chk("model_err_C", 32, 32'(e_err[32]), 32'd1);
    chk("model_mreq_D_end", 60, 32'(e_mreq[60]), 32'd1);
    // hand-computed pins on the observed waveform
    chk("reset_busy", 0, 32'(o_busy[0]), 32'd0);
    chk("reset_line_addr", 1, 32'(o_addr[1]), 32'd0);
    chk("A_dirty", 5, 32'(o_dirty[5]), 32'd1);
    chk("A_bus_req", 6, 32'(o_bus[6]), 32'd1);
    chk("A_wb_data", 7, 32'(o_data[7]), 32'hBEEF);
    chk("A_done_6th_cycle", 8, 32'(o_done[8]), 32'd1);
    chk("B_busy_low", 15, 32'(o_busy[15]), 32'd0);
    chk("B_no_dirty", 12, 32'(count(0, 12, 19)), 32'd0);
    chk("B_no_bus_req", 12, 32'(count(1, 12, 19)), 32'd0);
    chk("C_bus_req_cycles", 20, 32'(count(1, 20, 39)), 32'd6);
    chk("C_bursts", 20, 32'(count(5, 20, 39)), 32'd3);
    chk("C_err", 32, 32'(o_err[32]), 32'd1);
    chk("C_no_wb", 20, 32'(count(2, 20, 39)), 32'd0);
    chk("D_wb_cycles", 40, 32'(count(2, 40, 69)), 32'd10);
    chk("D_single_done", 40, 32'(count(3, 40, 69)), 32'd1);
    chk("D_no_err", 40, 32'(count(4, 40, 69)), 32'd0);
    chk("D_addr_kept", 58, 32'(o_addr[58]), 32'h05A);
    chk("D_data_kept", 58, 32'(o_data[58]), 32'hCAFE);
    chk("E_bus_req_reset", 74, 32'(o_bus[74]), 32'd0);
    chk("E_no_done_err", 70, 32'(count(3, 70, 75) + count(4, 70, 75)), 32'd0);
    chk("E_done_after", 85, 32'(o_done[85]), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
